// File: rtl/note_sprite_renderer_if.sv
// Note-table load port (valid/ready) for note_sprite_renderer.
// note_flip is present only when SPRITE_FLIP_EN is defined.
interface note_sprite_renderer_if;
  logic       note_valid;
  logic       note_ready;
  logic [9:0] note_x;
  logic [9:0] note_y;
`ifdef SPRITE_FLIP_EN
  logic       note_flip;
  modport master (output note_valid, note_x, note_y, note_flip, input note_ready);
  modport slave  (input note_valid, note_x, note_y, note_flip, output note_ready);
`else
  modport master (output note_valid, note_x, note_y, input note_ready);
  modport slave  (input note_valid, note_x, note_y, output note_ready);
`endif
endinterface

// File: rtl/note_sprite_renderer.sv
// Note-sprite renderer: double-buffered note table, per-pixel box hit, ROM address, pixel_on at +2.
// Optional SPRITE_FLIP_EN adds a per-entry 180-degree rotated address.
module note_sprite_lane #(
  parameter int SPR_W = 20,
  parameter int SPR_H = 30
) (
  input  logic       en,
  input  logic       video_on,
  input  logic       flip,
  input  logic [9:0] hcount,
  input  logic [9:0] vcount,
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic       hit,
  output logic [9:0] addr
);
  localparam logic [10:0] W11  = 11'(SPR_W);
  localparam logic [10:0] H11  = 11'(SPR_H);
  localparam logic [9:0]  W10  = 10'(SPR_W);
  localparam logic [9:0]  LAST = 10'(SPR_W*SPR_H-1);

  logic [10:0] dx, dy;
  logic [9:0]  lin;

  // Negative offsets wrap to >=1024 in 11 bits, so one unsigned compare covers both bounds.
  assign dx  = {1'b0, hcount} - {1'b0, x};
  assign dy  = {1'b0, vcount} - {1'b0, y};
  assign hit = en && video_on && (hcount < 10'd640) && (vcount < 10'd480) &&
               (dx < W11) && (dy < H11);
  assign lin  = dy[9:0] * W10 + dx[9:0];
  assign addr = flip ? LAST - lin : lin;
endmodule

module note_sprite_renderer #(
  parameter int SPR_W     = 20,
  parameter int SPR_H     = 30,
  parameter int MAX_NOTES = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  note_sprite_renderer_if.slave  note,
  input  logic                   commit,
  input  logic                   clear,
  input  logic [9:0]             hcount,
  input  logic [9:0]             vcount,
  input  logic                   video_on,
  output logic [9:0]             rom_addr,
  input  logic                   rom_pixel,
  output logic                   pixel_on,
  output logic                   busy
);
  localparam int CW = $clog2(MAX_NOTES+1);
  localparam int IW = (MAX_NOTES > 1) ? $clog2(MAX_NOTES) : 1;

  typedef enum logic {LOAD, PENDING} state_t;
  state_t state, state_nxt;

  logic [MAX_NOTES-1:0][9:0] shd_x, shd_y, act_x, act_y;
  logic [MAX_NOTES-1:0]      shd_f, act_f;
  logic [CW-1:0]             shd_cnt, act_cnt;
  logic                      frame_start, accept, flip_in;
  logic [MAX_NOTES-1:0]      hit;
  logic [MAX_NOTES-1:0][9:0] addr;
  logic [9:0]                win_addr;
  logic [2:1]                vld_pipe;

`ifdef SPRITE_FLIP_EN
  assign flip_in = note.note_flip;
`else
  assign flip_in = 1'b0;
`endif

  assign frame_start = (hcount == 10'd0) && (vcount == 10'd0);
  assign accept      = note.note_valid && note.note_ready;

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= LOAD;
    else          state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (commit)      state_nxt = PENDING;
      PENDING: if (frame_start) state_nxt = LOAD;
      default:                  state_nxt = LOAD;
    endcase
  end

  always_comb begin
    note.note_ready = 1'b0;
    busy            = 1'b0;
    case (state)
      LOAD:    note.note_ready = (shd_cnt < CW'(MAX_NOTES));
      PENDING: busy            = 1'b1;
      default: ;
    endcase
  end

  // Clear beats a same-cycle accept; publication copies the whole shadow at frame start.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      shd_cnt <= '0; shd_x <= '0; shd_y <= '0; shd_f <= '0;
      act_cnt <= '0; act_x <= '0; act_y <= '0; act_f <= '0;
    end else begin
      if (state == LOAD && clear) shd_cnt <= '0;
      else if (accept) begin
        shd_x[shd_cnt[IW-1:0]] <= note.note_x;
        shd_y[shd_cnt[IW-1:0]] <= note.note_y;
        shd_f[shd_cnt[IW-1:0]] <= flip_in;
        shd_cnt                <= shd_cnt + CW'(1);
      end
      if (state == PENDING && frame_start) begin
        act_x <= shd_x; act_y <= shd_y; act_f <= shd_f; act_cnt <= shd_cnt;
      end
    end

  for (genvar i = 0; i < MAX_NOTES; i++) begin : g_lane
    note_sprite_lane #(.SPR_W(SPR_W), .SPR_H(SPR_H)) u_lane (
      .en(CW'(i) < act_cnt), .video_on(video_on), .flip(act_f[i]),
      .hcount(hcount), .vcount(vcount), .x(act_x[i]), .y(act_y[i]),
      .hit(hit[i]), .addr(addr[i])
    );
  end

  // Scan high to low so the lowest-index hit lands last.
  always_comb begin
    win_addr = '0;
    for (int i = MAX_NOTES-1; i >= 0; i--)
      if (hit[i]) win_addr = addr[i];
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      rom_addr <= '0;
      vld_pipe <= '0;
      pixel_on <= 1'b0;
    end else begin
      rom_addr <= win_addr;
      vld_pipe <= {vld_pipe[1], |hit};
      pixel_on <= vld_pipe[2] & rom_pixel;
    end
endmodule

// File: tb/tb_note_sprite_renderer.sv
// Bench for note_sprite_renderer: directed steps plus random pixels against a box-geometry model.
`timescale 1ns/1ps
module tb_note_sprite_renderer;
  logic       clk = 1'b0;
  logic       reset_n, commit, clear, video_on, rom_pixel;
  logic [9:0] hcount, vcount, rom_addr;
  logic       pixel_on, busy;
  bit         rom_mem [1024];

  note_sprite_renderer_if nif();

  note_sprite_renderer dut (
    .clk(clk), .reset_n(reset_n), .note(nif), .commit(commit), .clear(clear),
    .hcount(hcount), .vcount(vcount), .video_on(video_on), .rom_addr(rom_addr),
    .rom_pixel(rom_pixel), .pixel_on(pixel_on), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rom_pixel <= rom_mem[rom_addr];

  int n_chk = 0, n_fail = 0;
  int shd_n, act_n;
  int shd_x[8], shd_y[8], act_x[8], act_y[8];
  bit shd_f[8], act_f[8];
  bit pend, cur_flip;
  bit h1, h2;
  int a1, a2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // First entry (lowest index) whose on-screen box contains the pixel.
  function automatic void ref_pix(input int h, input int v, input bit von,
                                  output bit hit, output int addr);
    hit = 0; addr = 0;
    for (int i = 0; i < act_n; i++) begin
      int dx, dy;
      dx = h - act_x[i];
      dy = v - act_y[i];
      if (!hit && von && h < 640 && v < 480 && dx >= 0 && dx < 20 && dy >= 0 && dy < 30) begin
        hit  = 1;
        addr = act_f[i] ? 599 - (dy*20 + dx) : dy*20 + dx;
      end
    end
  endfunction

  task automatic model_reset();
    shd_n = 0; act_n = 0; pend = 0; h1 = 0; h2 = 0; a1 = 0; a2 = 0;
  endtask

  // One clock: check handshake state, advance the model, then check the pipeline outputs.
  task automatic tick();
    bit h, rdy;
    int a;
    rdy = !pend && shd_n < 8;
    chk("note_ready", nif.note_ready, rdy);
    chk("busy", busy, pend);
    ref_pix(hcount, vcount, video_on, h, a);
    if (!pend) begin
      if (clear) shd_n = 0;
      else if (nif.note_valid && rdy) begin
        shd_x[shd_n] = nif.note_x; shd_y[shd_n] = nif.note_y; shd_f[shd_n] = cur_flip;
        shd_n++;
      end
      if (commit) pend = 1;
    end else if (hcount == 0 && vcount == 0) begin
      act_n = shd_n; act_x = shd_x; act_y = shd_y; act_f = shd_f; pend = 0;
    end
    @(posedge clk); #1;
    chk("rom_addr", rom_addr, h ? a : 0);
    chk("pixel_on", pixel_on, (h2 && rom_mem[a2]) ? 1 : 0);
    h2 = h1; a2 = a1; h1 = h; a1 = a;
  endtask

  task automatic px(input int h, input int v, input bit von);
    hcount = 10'(h); vcount = 10'(v); video_on = von;
    tick();
  endtask

  task automatic idle();
    hcount = 10'd700; vcount = 10'd500; video_on = 1'b0;
  endtask

  task automatic load(input int x, input int y, input bit f);
    nif.note_valid = 1'b1; nif.note_x = 10'(x); nif.note_y = 10'(y); cur_flip = f;
`ifdef SPRITE_FLIP_EN
    nif.note_flip = f;
`endif
    tick();
    nif.note_valid = 1'b0;
  endtask

  task automatic pulse_commit();
    commit = 1'b1; tick(); commit = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  initial begin
    int k, j, h, v;
    for (int i = 0; i < 1024; i++) rom_mem[i] = 1'($urandom_range(0, 1));
    rom_mem[0] = 1'b1; rom_mem[105] = 1'b1; rom_mem[599] = 1'b1;
    reset_n = 1'b0; commit = 1'b0; clear = 1'b0; cur_flip = 1'b0;
    nif.note_valid = 1'b0; nif.note_x = '0; nif.note_y = '0;
`ifdef SPRITE_FLIP_EN
    nif.note_flip = 1'b0;
`endif
    idle();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rom_addr", rom_addr, 0);
    chk("reset_pixel_on", pixel_on, 0);
    chk("reset_busy", busy, 0);
    reset_n = 1'b1;
    chk("reset_note_ready", nif.note_ready, 1);

    // Single note at (100,50): corners, just outside, and pixel pipeline.
    load(100, 50, 0);
    pulse_commit();
    chk("busy_after_commit", busy, 1);
    px(0, 0, 1);
    chk("busy_after_frame", busy, 0);
    px(100, 50, 1);  chk("addr_top_left", rom_addr, 0);
    px(119, 79, 1);  chk("addr_bottom_right", rom_addr, 599);
    px(99, 50, 1);   chk("addr_left_miss", rom_addr, 0);
    px(120, 50, 1);
    px(100, 80, 1);
    px(105, 55, 0);
    px(105, 55, 1);  chk("addr_inner", rom_addr, 105);
    idle(); tick(); tick();

    // Fill shadow table, hold a 9th entry, clear, 9th lands at index 0.
    pulse_clear();
    for (int i = 0; i < 8; i++) load($urandom_range(0, 600), $urandom_range(0, 450), 0);
    nif.note_valid = 1'b1; nif.note_x = 10'd400; nif.note_y = 10'd200; cur_flip = 1'b0;
`ifdef SPRITE_FLIP_EN
    nif.note_flip = 1'b0;
`endif
    repeat (3) tick();
    chk("full_not_ready", nif.note_ready, 0);
    clear = 1'b1; tick(); clear = 1'b0;
    chk("ready_after_clear", nif.note_ready, 1);
    tick();
    nif.note_valid = 1'b0;
    pulse_commit();
    px(0, 0, 1);
    px(405, 210, 1); chk("ninth_entry_addr", rom_addr, 205);

    // Overlapping boxes: entry 0 wins.
    idle(); pulse_clear();
    load(200, 100, 0); load(210, 100, 0);
    pulse_commit(); px(0, 0, 1);
    px(215, 110, 1); chk("overlap_entry0", rom_addr, 215);
    px(225, 110, 1); chk("overlap_entry1", rom_addr, 215);

    // Commit mid-frame: old table stays active until frame start.
    idle(); pulse_clear(); load(300, 300, 0);
    hcount = 10'd215; vcount = 10'd240; video_on = 1'b1; commit = 1'b1; tick(); commit = 1'b0;
    chk("busy_mid_frame", busy, 1);
    px(215, 110, 1); chk("old_table_live", rom_addr, 215);
    px(300, 300, 1); chk("new_table_hidden", rom_addr, 0);
    px(0, 0, 1);     chk("busy_cleared", busy, 0);
    px(300, 300, 1); chk("new_table_live", rom_addr, 0);
    px(310, 305, 1); chk("new_table_addr", rom_addr, 110);
    px(215, 110, 1); chk("old_table_gone", rom_addr, 0);

    // Accept with commit in one cycle; then clear+commit publishes empty.
    idle(); pulse_clear(); load(10, 10, 0);
    nif.note_valid = 1'b1; nif.note_x = 10'd630; nif.note_y = 10'd470; cur_flip = 1'b0;
`ifdef SPRITE_FLIP_EN
    nif.note_flip = 1'b0;
`endif
    commit = 1'b1; tick(); commit = 1'b0; nif.note_valid = 1'b0;
    px(0, 0, 1);
    px(639, 479, 1); chk("edge_box_addr", rom_addr, 189);
    px(640, 470, 1); chk("edge_box_clip", rom_addr, 0);
    px(12, 11, 1);   chk("same_cycle_commit", rom_addr, 22);
    idle(); clear = 1'b1; commit = 1'b1; tick(); clear = 1'b0; commit = 1'b0;
    px(0, 0, 1);
    px(12, 11, 1);   chk("empty_publish", rom_addr, 0);

`ifdef SPRITE_FLIP_EN
    idle(); pulse_clear(); load(0, 0, 1); load(630, 470, 0);
    pulse_commit(); px(0, 0, 1);
    px(0, 0, 1);     chk("flip_origin", rom_addr, 599);
    px(19, 29, 1);   chk("flip_far", rom_addr, 0);
`endif

    // Random tables and pixels clustered around the boxes.
    for (int r = 0; r < 6; r++) begin
      idle(); pulse_clear();
      k = $urandom_range(1, 8);
      for (int i = 0; i < k; i++)
`ifdef SPRITE_FLIP_EN
        load($urandom_range(0, 700), $urandom_range(0, 520), 1'($urandom_range(0, 1)));
`else
        load($urandom_range(0, 700), $urandom_range(0, 520), 0);
`endif
      pulse_commit();
      px(0, 0, 1);
      for (int n = 0; n < 150; n++) begin
        j = $urandom_range(0, k-1);
        h = act_x[j] + $urandom_range(0, 24) - 2;
        v = act_y[j] + $urandom_range(0, 34) - 2;
        if (h < 1) h = 1;
        if (h > 1023) h = 1023;
        if (v > 1023) v = 1023;
        px(h, v, $urandom_range(0, 7) != 0);
      end
    end

    // Asynchronous reset mid-line while a commit is pending.
    idle(); pulse_clear(); load(100, 50, 0); pulse_commit(); px(0, 0, 1);
    load(400, 400, 0); pulse_commit();
    px(105, 55, 1); px(105, 55, 1); px(105, 55, 1);
    #3 reset_n = 1'b0;
    #1;
    chk("async_rst_pixel_on", pixel_on, 0);
    chk("async_rst_rom_addr", rom_addr, 0);
    chk("async_rst_busy", busy, 0);
    model_reset();
    @(posedge clk); #1;
    reset_n = 1'b1;
    chk("async_rst_ready", nif.note_ready, 1);
    px(105, 55, 1); chk("table_emptied", rom_addr, 0);
    px(105, 55, 1); px(105, 55, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
